uart_rx_mmio: RTL and testbench

UART receiver with a memory-mapped read port: the receive-side counterpart of the existing transmit-only UART, sitting beside it on the core's data bus. It deserialises 8N1 frames from the board RX pin into a small FIFO. The core reads bytes and status through two MMIO addresses. The top level multiplexes `mmio_rdata` onto the core's read-data path whenever `mmio_hit` is high.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_mmio_if.sv | 11 +
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_mmio.sv | 151 +++++++++++++++
 tb/tb_uart_rx_mmio.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, status bit positions, baud divisor helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

   localparam int STAT_RX_VALID  = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_FRAME_ERR = 3;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Core-side MMIO read port of the UART receiver; the core is master, the receiver is slave.
// Read data and hit are combinational from the address; no backpressure.
interface uart_rx_mmio_if;
   logic [15:0] mmio_addr;
   logic        mmio_read;
   logic [7:0]  mmio_rdata;
   logic        mmio_hit;

   modport master (output mmio_addr, output mmio_read, input mmio_rdata, input mmio_hit);
   modport slave  (input mmio_addr, input mmio_read, output mmio_rdata, output mmio_hit);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with combinational head; push and pop take effect at the clock edge.
// A pop of a full FIFO frees the slot for a same-cycle push; a pop of an empty FIFO is ignored.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver feeding a small FIFO, read through DATA/STATUS MMIO addresses.
// Byte lands in the FIFO at the edge ending the stop bit; a full FIFO drops it and flags overrun.
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int          CLK_FREQ    = 27_000_000,
   parameter int          BAUD        = 115_200,
   parameter logic [15:0] DATA_ADDR   = 16'hFF10,
   parameter logic [15:0] STATUS_ADDR = 16'hFF11,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           rx,
   uart_rx_mmio_if.slave  bus,
   output logic           rx_valid
);

   localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

   logic          rx_meta_q;
   logic          rxs_q;
   rx_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          overrun_q, overrun_d;
   logic          frame_err_q, frame_err_d;

   logic          stop_done, push_req, pop_req, stat_clr;
   logic          data_sel, stat_sel;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_head;
   logic [7:0]    status_byte;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!rxs_q) begin
                  cnt_q   <= '0;
                  state_q <= START;
               end
            end
            // Mid-start-bit re-check rejects line glitches.
            START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rxs_q ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q     <= '0;
                  shift_q   <= {rxs_q, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_sel  = (bus.mmio_addr == DATA_ADDR);
   assign stat_sel  = (bus.mmio_addr == STATUS_ADDR);
   assign pop_req   = bus.mmio_read && data_sel;
   assign stat_clr  = bus.mmio_read && stat_sel;
   assign stop_done = (state_q == STOP) && (cnt_q == CNT_LAST);
   assign push_req  = stop_done && rxs_q;

   // A same-cycle pop of a full FIFO makes room, so only an unrelieved full FIFO overruns.
   assign overrun_d   = (push_req && fifo_full && !pop_req) || (overrun_q && !stat_clr);
   assign frame_err_d = (stop_done && !rxs_q) || (frame_err_q && !stat_clr);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push_req),
      .pop_i   (pop_req),
      .data_i  (shift_q),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      status_byte                 = 8'h00;
      status_byte[STAT_RX_VALID]  = !fifo_empty;
      status_byte[STAT_FULL]      = fifo_full;
      status_byte[STAT_OVERRUN]   = overrun_q;
      status_byte[STAT_FRAME_ERR] = frame_err_q;
   end

   always_comb begin
      bus.mmio_rdata = 8'h00;
      if (data_sel && !fifo_empty) begin
         bus.mmio_rdata = fifo_head;
      end else if (stat_sel) begin
         bus.mmio_rdata = status_byte;
      end
   end

   assign bus.mmio_hit = data_sel || stat_sel;
   assign rx_valid     = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at default clock/baud (234 clocks per bit).
// Frames are driven on the falling clock edge; outputs are sampled away from the rising edge.
module tb_uart_rx_mmio;

   localparam int          CPB      = 234;
   localparam logic [15:0] A_DATA   = 16'hFF10;
   localparam logic [15:0] A_STATUS = 16'hFF11;

   logic clock;
   logic reset;
   logic rx;
   logic rx_valid;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx_mmio_if bus ();

   uart_rx_mmio dut (
      .clock    (clock),
      .reset    (reset),
      .rx       (rx),
      .bus      (bus.slave),
      .rx_valid (rx_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Caller must be at a falling edge; drives a full 10-bit frame.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clock);
      end
      rx = stop_bit;
      if (stop_bit) begin
         repeat (CPB) @(negedge clock);
      end else begin
         repeat (140) @(negedge clock);
         rx = 1'b1;
         repeat (CPB - 140) @(negedge clock);
      end
   endtask

   task automatic peek(input logic [15:0] a, output logic [7:0] d, output logic h);
      @(negedge clock);
      bus.mmio_addr = a;
      bus.mmio_read = 1'b0;
      #1;
      d = bus.mmio_rdata;
      h = bus.mmio_hit;
   endtask

   task automatic read_reg(input logic [15:0] a, output logic [7:0] d);
      @(negedge clock);
      bus.mmio_addr = a;
      bus.mmio_read = 1'b1;
      #1;
      d = bus.mmio_rdata;
      @(negedge clock);
      bus.mmio_read = 1'b0;
      bus.mmio_addr = 16'h0000;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d;
      logic       h;

      reset         = 1'b0;
      rx            = 1'b1;
      bus.mmio_addr = 16'h0000;
      bus.mmio_read = 1'b0;
      idle(4);
      check_eq("reset_rx_valid", 32'(rx_valid), 32'h0);
      peek(A_STATUS, d, h);
      check_eq("reset_status", 32'(d), 32'h00);
      check_eq("hit_status", 32'(h), 32'h1);
      peek(A_DATA, d, h);
      check_eq("reset_data", 32'(d), 32'h00);
      check_eq("hit_data", 32'(h), 32'h1);
      peek(16'hFF12, d, h);
      check_eq("miss_hit", 32'(h), 32'h0);
      check_eq("miss_rdata", 32'(d), 32'h00);
      @(negedge clock);
      reset = 1'b1;
      idle(5);

      // Single frame with exact push timing: rx_valid rises after the 2226th rising edge.
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (2225) @(negedge clock);
            check_eq("a5_pre_push_valid", 32'(rx_valid), 32'h0);
            @(negedge clock);
            check_eq("a5_post_push_valid", 32'(rx_valid), 32'h1);
         end
      join
      idle(5);
      peek(A_STATUS, d, h);
      check_eq("a5_status", 32'(d), 32'h01);
      read_reg(A_DATA, d);
      check_eq("a5_data", 32'(d), 32'hA5);
      check_eq("a5_valid_after_pop", 32'(rx_valid), 32'h0);
      peek(A_STATUS, d, h);
      check_eq("a5_status_after_pop", 32'(d), 32'h00);

      // Short low glitch on idle line is rejected; a following frame still works.
      idle(10);
      rx = 1'b0;
      idle(50);
      rx = 1'b1;
      idle(300);
      peek(A_STATUS, d, h);
      check_eq("glitch_status", 32'(d), 32'h00);
      idle(1);
      send_frame(8'h5A, 1'b1);
      idle(20);
      read_reg(A_DATA, d);
      check_eq("post_glitch_data", 32'(d), 32'h5A);

      // Five back-to-back frames into a depth-4 FIFO.
      idle(10);
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      idle(20);
      peek(A_STATUS, d, h);
      check_eq("ovr_status_peek", 32'(d), 32'h07);
      read_reg(A_STATUS, d);
      check_eq("ovr_status_read", 32'(d), 32'h07);
      for (int i = 1; i <= 4; i++) begin
         read_reg(A_DATA, d);
         check_eq("ovr_drain", 32'(d), 32'(i));
      end
      read_reg(A_STATUS, d);
      check_eq("ovr_status_drained", 32'(d), 32'h00);
      read_reg(A_DATA, d);
      check_eq("empty_data_read", 32'(d), 32'h00);

      // Stop bit low: byte dropped, frame error flagged, cleared by a status read.
      idle(10);
      send_frame(8'h3C, 1'b0);
      idle(300);
      check_eq("ferr_valid", 32'(rx_valid), 32'h0);
      peek(A_STATUS, d, h);
      check_eq("ferr_status_peek", 32'(d), 32'h08);
      read_reg(A_STATUS, d);
      check_eq("ferr_status_read", 32'(d), 32'h08);
      read_reg(A_STATUS, d);
      check_eq("ferr_status_reread", 32'(d), 32'h00);

      // Reset mid-frame discards the frame and any queued byte.
      idle(10);
      send_frame(8'h77, 1'b1);
      idle(20);
      peek(A_STATUS, d, h);
      check_eq("pre_reset_status", 32'(d), 32'h01);
      idle(1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (1000) @(negedge clock);
            reset = 1'b0;
            #1;
            check_eq("midreset_valid", 32'(rx_valid), 32'h0);
            peek(A_DATA, d, h);
            check_eq("midreset_data", 32'(d), 32'h00);
            idle(2);
            reset = 1'b1;
         end
      join
      idle(50);
      send_frame(8'h42, 1'b1);
      idle(50);
      peek(A_STATUS, d, h);
      check_eq("after_reset_status", 32'(d), 32'h01);
      read_reg(A_DATA, d);
      check_eq("after_reset_data", 32'(d), 32'h42);
      peek(A_STATUS, d, h);
      check_eq("after_reset_flags", 32'(d), 32'h00);

      // Full FIFO with a DATA pop landing on the very edge that ends STOP.
      idle(5);
      for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
      idle(20);
      peek(A_STATUS, d, h);
      check_eq("full_status", 32'(d), 32'h03);
      idle(1);
      fork
         send_frame(8'h15, 1'b1);
         begin
            repeat (2225) @(negedge clock);
            bus.mmio_addr = A_DATA;
            bus.mmio_read = 1'b1;
            #1;
            check_eq("race_pop_data", 32'(bus.mmio_rdata), 32'h11);
            @(posedge clock);
            #1;
            bus.mmio_read = 1'b0;
            bus.mmio_addr = 16'h0000;
         end
      join
      idle(20);
      peek(A_STATUS, d, h);
      check_eq("race_status", 32'(d), 32'h03);
      for (int i = 0; i < 4; i++) begin
         read_reg(A_DATA, d);
         check_eq("race_drain", 32'(d), 32'h12 + 32'(i));
      end
      peek(A_STATUS, d, h);
      check_eq("race_final_status", 32'(d), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
